// File: rtl/arb_merge_rr_n.sv
// arb_merge_rr_n_fifo: one channel's input queue.
//   Holds DEPTH entries. A write to a full queue is dropped and sets a sticky
//   overflow flag. Fullness is judged on the occupancy at the start of the
//   cycle, so a pop at the same edge does not make room for the write.
//   Ports: clk/rstn, push + din (write), pop (read), nempty, head (oldest
//   entry), ovf (sticky overflow flag).
module arb_merge_rr_n_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         nempty,
  output logic [W-1:0] head,
  output logic         ovf
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [PW-1:0]           rd_ptr, wr_ptr;
  logic [CW-1:0]           cnt;
  logic                    full, do_push, do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign nempty  = (cnt != '0);
  assign do_push = push && !full;
  assign do_pop  = pop && nempty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
      if (push && full) ovf <= 1'b1;
    end
  end

  // Storage needs no reset: nothing reads an entry before it is written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// arb_merge_rr_n: N-channel arbiter-merge onto a single drive/free handshake.
//   Each channel owns a DEPTH-entry queue. In IDLE, a non-empty queue is
//   granted (round-robin or fixed priority), its head is registered onto
//   o_data/o_chan, and o_driveNext plus o_free[g] pulse the next cycle. The
//   block then sits in WAIT until downstream returns i_freeNext.
//   Ports:
//     clk, rstn        clock, async active-low reset
//     i_drive, i_data  per-channel write pulses and flattened payloads
//     o_free           per-channel credit-return pulse
//     o_driveNext      output-valid pulse; o_data/o_chan held until next transfer
//     i_freeNext       downstream consumed the current output
//     o_overflow       sticky per-channel overflow flags
module arb_merge_rr_n #(
  parameter int NUM_CH     = 8,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 2,
  parameter int ARB_MODE   = 1,
  parameter int CH_W       = $clog2(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [NUM_CH-1:0]            i_drive,
  input  logic [NUM_CH*DATA_WIDTH-1:0] i_data,
  output logic [NUM_CH-1:0]            o_free,
  output logic                         o_driveNext,
  output logic [DATA_WIDTH-1:0]        o_data,
  output logic [CH_W-1:0]              o_chan,
  input  logic                         i_freeNext,
  output logic [NUM_CH-1:0]            o_overflow
);
  typedef enum logic {IDLE, WAIT} st_t;

  st_t                          state;
  logic [CH_W-1:0]              rr_ptr;
  logic [NUM_CH-1:0]            nempty, pop_vec, gnt_oh;
  logic [NUM_CH*DATA_WIDTH-1:0] head_flat;
  logic                         gnt_vld;
  logic [CH_W-1:0]              gnt;
  int                           sel;

  arb_merge_rr_n_fifo #(.W(DATA_WIDTH), .DEPTH(DEPTH)) u_fifo [NUM_CH-1:0] (
    .clk    (clk),
    .rstn   (rstn),
    .push   (i_drive),
    .din    (i_data),
    .pop    (pop_vec),
    .nempty (nempty),
    .head   (head_flat),
    .ovf    (o_overflow)
  );

  // Search starts at rr_ptr in round-robin mode, at channel 0 otherwise;
  // the first non-empty channel found wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = '0;
    sel     = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      sel = (ARB_MODE != 0) ? (int'(rr_ptr) + i) % NUM_CH : i;
      if (!gnt_vld && nempty[CH_W'(sel)]) begin
        gnt_vld = 1'b1;
        gnt     = CH_W'(sel);
      end
    end
  end

  assign gnt_oh  = NUM_CH'(1) << gnt;
  assign pop_vec = (state == IDLE && gnt_vld) ? gnt_oh : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      o_data      <= '0;
      o_chan      <= '0;
      o_driveNext <= 1'b0;
      o_free      <= '0;
    end else begin
      o_driveNext <= 1'b0;
      o_free      <= '0;
      case (state)
        IDLE: begin
          if (gnt_vld) begin
            o_data      <= head_flat[gnt*DATA_WIDTH +: DATA_WIDTH];
            o_chan      <= gnt;
            o_driveNext <= 1'b1;
            o_free      <= gnt_oh;
            state       <= WAIT;
            if (ARB_MODE != 0)
              rr_ptr <= (gnt == CH_W'(NUM_CH - 1)) ? '0 : gnt + 1'b1;
          end
        end
        WAIT: if (i_freeNext) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_arb_merge_rr_n.sv
// Bench for arb_merge_rr_n: a round-robin instance and a fixed-priority
// instance share stimulus, steered by sel_fp. Expected transfers are queued
// as they are driven and popped when o_driveNext appears.
module tb_arb_merge_rr_n;
  localparam int N  = 8;
  localparam int DW = 8;

  typedef struct {
    logic [2:0] ch;
    logic [7:0] d;
  } exp_t;

  logic          clk = 1'b0;
  logic          rstn;
  logic [N-1:0]  drv;
  logic [N*DW-1:0] dat;
  logic          fnx;
  logic          sel_fp;

  logic [N-1:0]  rr_free, fp_free, rr_ovf, fp_ovf;
  logic          rr_dn, fp_dn;
  logic [DW-1:0] rr_data, fp_data;
  logic [2:0]    rr_chan, fp_chan;

  logic [N-1:0]  o_free, o_ovf;
  logic          o_dn;
  logic [DW-1:0] o_data;
  logic [2:0]    o_chan;

  int   ntot, npass, stray;
  bit   got;
  exp_t sb[$];

  always #5 clk = ~clk;

  arb_merge_rr_n #(.ARB_MODE(1)) u_rr (
    .clk(clk), .rstn(rstn),
    .i_drive(sel_fp ? '0 : drv), .i_data(dat),
    .o_free(rr_free), .o_driveNext(rr_dn), .o_data(rr_data), .o_chan(rr_chan),
    .i_freeNext(sel_fp ? 1'b0 : fnx), .o_overflow(rr_ovf)
  );

  arb_merge_rr_n #(.ARB_MODE(0)) u_fp (
    .clk(clk), .rstn(rstn),
    .i_drive(sel_fp ? drv : '0), .i_data(dat),
    .o_free(fp_free), .o_driveNext(fp_dn), .o_data(fp_data), .o_chan(fp_chan),
    .i_freeNext(sel_fp ? fnx : 1'b0), .o_overflow(fp_ovf)
  );

  assign o_free = sel_fp ? fp_free : rr_free;
  assign o_dn   = sel_fp ? fp_dn   : rr_dn;
  assign o_data = sel_fp ? fp_data : rr_data;
  assign o_chan = sel_fp ? fp_chan : rr_chan;
  assign o_ovf  = sel_fp ? fp_ovf  : rr_ovf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    ntot++;
    assert (obs === exp_v) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [2:0] ch, input logic [7:0] d);
    exp_t e;
    e.ch = ch;
    e.d  = d;
    sb.push_back(e);
  endtask

  task automatic drive1(input int ch, input logic [7:0] d);
    dat = '0;
    dat[ch*DW +: DW] = d;
    drv = N'(1) << ch;
    tick();
    drv = '0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_dn"},   32'(o_dn),   0);
    chk({tag, "_free"}, 32'(o_free), 0);
    chk({tag, "_data"}, 32'(o_data), 0);
    chk({tag, "_chan"}, 32'(o_chan), 0);
    chk({tag, "_ovf"},  32'(o_ovf),  0);
  endtask

  // Counts any pulse over n cycles; none is expected.
  task automatic quiet(input string tag, input int n);
    int c;
    c = 0;
    for (int t = 0; t < n; t++) begin
      if (o_dn || o_free != '0) c++;
      tick();
    end
    chk(tag, c, 0);
  endtask

  // Waits for o_driveNext, compares against the scoreboard head, then
  // (optionally) returns i_freeNext the following cycle together with a
  // refill drive on rmask.
  task automatic get_out(input string tag, input bit do_free,
                         input logic [N-1:0] rmask, input logic [7:0] rdat);
    exp_t e;
    bit   g;
    g = 1'b0;
    for (int t = 0; t < 40 && !g; t++) begin
      if (o_dn) begin
        g = 1'b1;
        chk({tag, "_sbsz"}, (sb.size() > 0) ? 32'd1 : 32'd0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk({tag, "_chan"}, 32'(o_chan), 32'(e.ch));
          chk({tag, "_data"}, 32'(o_data), 32'(e.d));
          chk({tag, "_free"}, 32'(o_free), 32'(N'(1) << e.ch));
        end
      end else if (o_free != '0) begin
        stray++;
      end
      tick();
    end
    chk({tag, "_tmo"}, 32'(g), 1);
    if (g && do_free) begin
      fnx = 1'b1;
      drv = rmask;
      for (int k = 0; k < N; k++) dat[k*DW +: DW] = rdat;
      tick();
      fnx = 1'b0;
      drv = '0;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    ntot = 0; npass = 0; stray = 0;
    rstn = 1'b0; drv = '0; dat = '0; fnx = 1'b0; sel_fp = 1'b0;
    repeat (3) tick();
    chk_zero("rst");
    rstn = 1'b1;
    tick();

    // Latency: stray i_freeNext in IDLE is ignored; drive ch4 -> pulses 2 cycles later.
    fnx = 1'b1; tick(); fnx = 1'b0; tick();
    drive1(4, 8'h5C);
    chk("lat_n1_dn", 32'(o_dn), 0);
    tick();
    chk("lat_n2_dn",   32'(o_dn),   1);
    chk("lat_n2_chan", 32'(o_chan), 4);
    chk("lat_n2_data", 32'(o_data), 32'h5C);
    chk("lat_n2_free", 32'(o_free), 32'h10);
    tick();
    drive1(1, 8'h1B);
    quiet("hold_quiet", 18);
    chk("hold_data", 32'(o_data), 32'h5C);
    fnx = 1'b1; tick(); fnx = 1'b0;
    chk("rel_m1_dn", 32'(o_dn), 0);
    tick();
    chk("rel_m2_dn",   32'(o_dn),   1);
    chk("rel_m2_chan", 32'(o_chan), 1);
    chk("rel_m2_data", 32'(o_data), 32'h1B);
    chk("rel_m2_free", 32'(o_free), 32'h02);
    tick();
    fnx = 1'b1; tick(); fnx = 1'b0;

    // Reset while in WAIT with ch2 and ch5 queued.
    dat = '0; dat[2*DW +: DW] = 8'hC1; dat[5*DW +: DW] = 8'hC5; drv = 8'h24; tick();
    dat[2*DW +: DW] = 8'hC2; drv = 8'h04; tick(); drv = '0;
    got = 1'b0;
    for (int t = 0; t < 10 && !got; t++) begin
      if (o_dn) got = 1'b1;
      else tick();
    end
    chk("mid_seen", 32'(got), 1);
    chk("mid_chan", 32'(o_chan), 2);
    tick();
    rstn = 1'b0; tick(); tick(); rstn = 1'b1;
    chk_zero("mid_rst");
    tick();
    quiet("mid_quiet", 10);

    // Round-robin, all channels in one cycle.
    for (int k = 0; k < N; k++) begin
      dat[k*DW +: DW] = 8'(8'h10 + k);
      push_exp(3'(k), 8'(8'h10 + k));
    end
    drv = '1; tick(); drv = '0;
    stray = 0;
    for (int i = 0; i < N; i++) get_out("rr_all", 1'b1, '0, 8'h00);
    chk("rr_all_stray", stray, 0);
    chk("rr_all_ovf", 32'(o_ovf), 0);

    // Wrap fairness: ch0 and ch7 refilled on every free.
    dat = '0; dat[0 +: DW] = 8'h30; dat[7*DW +: DW] = 8'h70; drv = 8'h81; tick();
    dat[0 +: DW] = 8'h31; dat[7*DW +: DW] = 8'h71; tick(); drv = '0;
    for (int i = 0; i < 10; i++)
      push_exp((i % 2) ? 3'd7 : 3'd0, 8'(((i % 2) ? 8'h70 : 8'h30) + i / 2));
    for (int i = 0; i < 10; i++) begin
      if (i < 6)
        get_out("wrap", 1'b1, (i % 2) ? 8'h80 : 8'h01,
                8'(((i % 2) ? 8'h70 : 8'h30) + 2 + i / 2));
      else
        get_out("wrap", 1'b1, '0, 8'h00);
    end

    // Overflow: downstream stalled on ch6, ch3 driven three times.
    drive1(6, 8'h66);
    push_exp(3'd6, 8'h66);
    get_out("ovf_stall", 1'b0, '0, 8'h00);
    drive1(3, 8'hA1);
    drive1(3, 8'hA2);
    drive1(3, 8'hA3);
    chk("ovf_set", 32'(o_ovf), 32'h08);
    fnx = 1'b1; tick(); fnx = 1'b0;
    push_exp(3'd3, 8'hA1);
    push_exp(3'd3, 8'hA2);
    get_out("ovf_out", 1'b1, '0, 8'h00);
    get_out("ovf_out", 1'b1, '0, 8'h00);
    quiet("ovf_quiet", 8);
    chk("ovf_sticky", 32'(o_ovf), 32'h08);
    chk("ovf_sb_empty", sb.size(), 0);

    // Fixed priority: ch0 refill after the ch2 transfer preempts ch3..7.
    sel_fp = 1'b1;
    tick();
    for (int k = 0; k < N; k++) dat[k*DW +: DW] = 8'(8'h10 + k);
    drv = '1; tick(); drv = '0;
    push_exp(3'd0, 8'h10); push_exp(3'd1, 8'h11); push_exp(3'd2, 8'h12);
    push_exp(3'd0, 8'h20);
    for (int k = 3; k < N; k++) push_exp(3'(k), 8'(8'h10 + k));
    for (int i = 0; i < 9; i++)
      get_out("fp", 1'b1, (i == 2) ? 8'h01 : 8'h00, 8'h20);
    chk("fp_sb_empty", sb.size(), 0);
    chk("fp_ovf", 32'(o_ovf), 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
